// File: rtl/cpu_bus_if.sv
// Signal bundle between the Dendy CPU bus responder and the CPU, RAM, PPU,
// cartridge and joypads. The responder uses the slave view.
interface cpu_bus_if;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic        cpu_r;
    logic        cpu_w;
    logic [7:0]  cpu_i;
    logic        cpu_ce;
    logic [10:0] ram_a;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q;
    logic        ram_we;
    logic [2:0]  ppu_a;
    logic [7:0]  ppu_d;
    logic [7:0]  ppu_q;
    logic        ppu_r;
    logic        ppu_w;
    logic [15:0] cart_a;
    logic [7:0]  cart_d;
    logic [7:0]  cart_q;
    logic        cart_w;
    logic [7:0]  joy1;
    logic [7:0]  joy2;

    modport slave (
        input  cpu_a, cpu_d, cpu_r, cpu_w, ram_q, ppu_q, cart_q, joy1, joy2,
        output cpu_i, cpu_ce, ram_a, ram_d, ram_we, ppu_a, ppu_d, ppu_r, ppu_w,
               cart_a, cart_d, cart_w
    );

    modport master (
        output cpu_a, cpu_d, cpu_r, cpu_w, ram_q, ppu_q, cart_q, joy1, joy2,
        input  cpu_i, cpu_ce, ram_a, ram_d, ram_we, ppu_a, ppu_d, ppu_r, ppu_w,
               cart_a, cart_d, cart_w
    );
endinterface

// File: rtl/cpu_bus.sv
// Dendy CPU bus responder: CPU clock-enable generation, address decode for
// RAM/PPU/joypads/cartridge, registered read data and the $4014 OAM DMA engine.
module cpu_bus #(
    parameter int unsigned CE_DIV = 14
) (
    input  logic     clock,
    input  logic     reset_n,
    cpu_bus_if.slave bus
);
    localparam logic [7:0] PH_LAST  = 8'(CE_DIV - 1);
    localparam logic [9:0] DMA_LAST = 10'd512;

    typedef enum logic [1:0] {ST_CPU, ST_ARMED, ST_DMA} state_t;

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [9:0]  dma_cnt_q, dma_cnt_d;
    logic [7:0]  cpu_i_q, cpu_i_d;
    logic        joy_strobe_q, joy_strobe_d;
    logic [7:0]  sr1_q, sr1_d;
    logic [7:0]  sr2_q, sr2_d;
    logic [7:0]  dma_page_q;
    logic [7:0]  dma_data_q;

    logic        ph1, ph3, wrap;
    logic        cpu_rd, cpu_wr, dma_start;
    logic [7:0]  dma_idx;
    logic [15:0] bus_a;
    logic        bus_rd, bus_wr, dma_rd;
    logic        sel_ram, sel_ppu, sel_io, sel_cart;
    logic [7:0]  io_q, rd_mux;

    assign ph1       = (phase_q == 8'd1);
    assign ph3       = (phase_q == 8'd3);
    assign wrap      = (phase_q == PH_LAST);
    assign cpu_rd    = bus.cpu_r;
    assign cpu_wr    = bus.cpu_w & ~bus.cpu_r;
    assign dma_start = (state_q == ST_CPU) && ph1 && cpu_wr && (bus.cpu_a == 16'h4014);
    // Period 0 of a DMA is idle; odd periods read idx, even periods write it.
    assign dma_idx   = 8'((dma_cnt_q - 10'd1) >> 1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_CPU;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        dma_cnt_d = dma_cnt_q;
        case (state_q)
            ST_CPU:   if (dma_start) state_d = ST_ARMED;
            ST_ARMED: if (wrap) begin
                state_d   = ST_DMA;
                dma_cnt_d = 10'd0;
            end
            ST_DMA:   if (wrap) begin
                if (dma_cnt_q == DMA_LAST) state_d = ST_CPU;
                else                       dma_cnt_d = dma_cnt_q + 10'd1;
            end
            default:  state_d = ST_CPU;
        endcase
    end

    always_comb begin
        bus_a  = bus.cpu_a;
        bus_rd = cpu_rd;
        bus_wr = cpu_wr;
        dma_rd = 1'b0;
        if (state_q == ST_DMA) begin
            bus_a  = {dma_page_q, dma_idx};
            bus_rd = 1'b0;
            bus_wr = 1'b0;
            if (dma_cnt_q != 10'd0) begin
                if (dma_cnt_q[0]) begin
                    bus_rd = 1'b1;
                    dma_rd = 1'b1;
                end else begin
                    bus_a  = 16'h2004;
                    bus_wr = 1'b1;
                end
            end
        end
    end

    assign sel_ram  = (bus_a[15:13] == 3'b000);
    assign sel_ppu  = (bus_a[15:13] == 3'b001);
    assign sel_io   = (bus_a[15:5] == 11'h200);
    assign sel_cart = ~(sel_ram | sel_ppu | sel_io);

    always_comb begin
        io_q = 8'h00;
        if (bus_a[4:0] == 5'h16)      io_q = {7'b0100000, sr1_q[0]};
        else if (bus_a[4:0] == 5'h17) io_q = {7'b0100000, sr2_q[0]};
    end

    always_comb begin
        if (sel_ram)      rd_mux = bus.ram_q;
        else if (sel_ppu) rd_mux = bus.ppu_q;
        else if (sel_io)  rd_mux = io_q;
        else              rd_mux = bus.cart_q;
    end

    always_comb begin
        phase_d      = wrap ? 8'd0 : phase_q + 8'd1;
        cpu_i_d      = cpu_i_q;
        joy_strobe_d = joy_strobe_q;
        sr1_d        = sr1_q;
        sr2_d        = sr2_q;
        if (ph3 && bus_rd && (state_q != ST_DMA)) cpu_i_d = rd_mux;
        if (ph1 && bus_wr && (bus_a == 16'h4016)) joy_strobe_d = bus.cpu_d[0];
        // Shift happens on the same edge as the capture, so the read sees bit 0 first.
        if (joy_strobe_q) begin
            sr1_d = bus.joy1;
            sr2_d = bus.joy2;
        end else if (ph3 && bus_rd) begin
            if (bus_a == 16'h4016) sr1_d = {1'b1, sr1_q[7:1]};
            if (bus_a == 16'h4017) sr2_d = {1'b1, sr2_q[7:1]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q      <= 8'd0;
            dma_cnt_q    <= 10'd0;
            cpu_i_q      <= 8'h00;
            joy_strobe_q <= 1'b0;
            sr1_q        <= 8'h00;
            sr2_q        <= 8'h00;
        end else begin
            phase_q      <= phase_d;
            dma_cnt_q    <= dma_cnt_d;
            cpu_i_q      <= cpu_i_d;
            joy_strobe_q <= joy_strobe_d;
            sr1_q        <= sr1_d;
            sr2_q        <= sr2_d;
        end
    end

    always_ff @(posedge clock) begin
        if (dma_start)    dma_page_q <= bus.cpu_d;
        if (ph3 && dma_rd) dma_data_q <= rd_mux;
    end

    assign bus.cpu_i  = cpu_i_q;
    assign bus.cpu_ce = wrap && (state_q != ST_DMA);
    assign bus.ram_a  = bus_a[10:0];
    assign bus.ram_d  = bus.cpu_d;
    assign bus.ram_we = ph1 && bus_wr && sel_ram;
    assign bus.ppu_a  = bus_a[2:0];
    assign bus.ppu_d  = (state_q == ST_DMA) ? dma_data_q : bus.cpu_d;
    assign bus.ppu_r  = ph1 && bus_rd && sel_ppu;
    assign bus.ppu_w  = ph1 && bus_wr && sel_ppu;
    assign bus.cart_a = bus_a;
    assign bus.cart_d = bus.cpu_d;
    assign bus.cart_w = ph1 && bus_wr && sel_cart;
endmodule

// File: tb/tb_cpu_bus.sv
// Bench for cpu_bus: directed scenarios plus random CPU accesses checked
// against a region-level reference model of the Dendy memory map.
module tb_cpu_bus;
    localparam int CE_DIV = 14;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    cpu_bus_if bus ();
    cpu_bus #(.CE_DIV(CE_DIV)) dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    // Peripheral models: RAM/cart answer one clock after the address, PPU after ppu_r.
    logic [7:0] mem [0:2047];
    logic [7:0] ppu_regs [0:7];
    bit mem_ready = 1'b0;

    function automatic logic [7:0] cart_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
            mem_ready <= 1'b1;
        end else begin
            bus.ram_q <= mem[bus.ram_a];
            if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d;
        end
        if (bus.ppu_r) bus.ppu_q <= ppu_regs[bus.ppu_a];
        bus.cart_q <= cart_val(bus.cart_a);
    end

    int n_ram_we = 0, n_ppu_w = 0, n_ppu_r = 0, n_cart_w = 0;
    logic [10:0] ram_la;  logic [7:0] ram_ld;
    logic [2:0]  ppu_la;  logic [7:0] ppu_ld;  logic [2:0] ppu_ra;
    logic [15:0] cart_la; logic [7:0] cart_ld;
    logic [10:0] ppu_wq [$];

    always @(posedge clock) begin
        if (bus.ram_we) begin n_ram_we++; ram_la = bus.ram_a; ram_ld = bus.ram_d; end
        if (bus.ppu_w) begin
            n_ppu_w++; ppu_la = bus.ppu_a; ppu_ld = bus.ppu_d;
            ppu_wq.push_back({bus.ppu_a, bus.ppu_d});
        end
        if (bus.ppu_r) begin n_ppu_r++; ppu_ra = bus.ppu_a; end
        if (bus.cart_w) begin n_cart_w++; cart_la = bus.cart_a; cart_ld = bus.cart_d; end
    end

    // Reference model of the memory map and joypads.
    logic [7:0] ref_ram [0:2047];
    logic [7:0] ref_i;
    bit         ref_strobe;
    logic [7:0] ref_lat [2];
    int         ref_n [2];

    task automatic ref_reset();
        ref_i = 8'h00; ref_strobe = 1'b0;
        ref_lat[0] = 8'h00; ref_lat[1] = 8'h00; ref_n[0] = 0; ref_n[1] = 0;
    endtask

    function automatic logic [7:0] joy_now(input int p);
        return (p == 0) ? bus.joy1 : bus.joy2;
    endfunction

    task automatic ref_joy_read(input int p, output logic [7:0] v);
        logic bitv;
        if (ref_strobe) begin
            ref_lat[p] = joy_now(p);
            bitv = ref_lat[p][0];
        end else begin
            bitv = (ref_n[p] < 8) ? ref_lat[p][ref_n[p]] : 1'b1;
            ref_n[p]++;
        end
        v = {7'b0100000, bitv};
    endtask

    // exp_s = {ram_we, ppu_w, ppu_r, cart_w}
    task automatic ref_access(input bit r, input bit w, input logic [15:0] a, input logic [7:0] d,
                              output logic [7:0] exp_q, output logic [3:0] exp_s);
        bit is_ram, is_ppu, is_io, is_wr;
        is_ram = a < 16'h2000;
        is_ppu = !is_ram && a < 16'h4000;
        is_io  = !is_ram && !is_ppu && a < 16'h4020;
        is_wr  = w && !r;
        exp_s  = {is_wr && is_ram, is_wr && is_ppu, r && is_ppu,
                  is_wr && !is_ram && !is_ppu && !is_io};
        if (r) begin
            if (is_ram)            ref_i = ref_ram[a % 2048];
            else if (is_ppu)       ref_i = ppu_regs[a % 8];
            else if (a == 16'h4016) ref_joy_read(0, ref_i);
            else if (a == 16'h4017) ref_joy_read(1, ref_i);
            else if (is_io)        ref_i = 8'h00;
            else                   ref_i = cart_val(a);
        end else if (is_wr) begin
            if (is_ram) ref_ram[a % 2048] = d;
            if (a == 16'h4016) begin
                if (!d[0] && ref_strobe) begin
                    ref_lat[0] = bus.joy1; ref_lat[1] = bus.joy2;
                    ref_n[0] = 0; ref_n[1] = 0;
                end
                ref_strobe = d[0];
            end
        end
        exp_q = ref_i;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered #1 after the edge that starts phase 0; returns at the same point of the next period.
    task automatic cpu_cycle(input bit r, input bit w, input logic [15:0] a, input logic [7:0] d,
                             output logic [7:0] q);
        int n;
        bus.cpu_r = r; bus.cpu_w = w; bus.cpu_a = a; bus.cpu_d = d;
        n = 0;
        for (int i = 1; i <= 2 * CE_DIV; i++) begin
            @(negedge clock);
            if (bus.cpu_ce) begin n = i; break; end
        end
        chk("ce_period", n, CE_DIV);
        @(posedge clock); #1;
        bus.cpu_r = 1'b0; bus.cpu_w = 1'b0;
        q = bus.cpu_i;
    endtask

    task automatic do_access(input bit r, input bit w, input logic [15:0] a, input logic [7:0] d,
                             output logic [7:0] q);
        logic [7:0] exp_q; logic [3:0] exp_s;
        int b_rw, b_pw, b_pr, b_cw;
        ref_access(r, w, a, d, exp_q, exp_s);
        b_rw = n_ram_we; b_pw = n_ppu_w; b_pr = n_ppu_r; b_cw = n_cart_w;
        cpu_cycle(r, w, a, d, q);
        chk("strobe_counts",
            ((n_ram_we - b_rw) << 12) | ((n_ppu_w - b_pw) << 8) | ((n_ppu_r - b_pr) << 4) | (n_cart_w - b_cw),
            32'({3'b0, exp_s[3], 3'b0, exp_s[2], 3'b0, exp_s[1], 3'b0, exp_s[0]}));
        chk("cpu_i", 32'(q), 32'(exp_q));
        if (exp_s[3]) begin chk("ram_a", 32'(ram_la), 32'(a[10:0])); chk("ram_d", 32'(ram_ld), 32'(d)); end
        if (exp_s[2]) begin chk("ppu_wa", 32'(ppu_la), 32'(a[2:0])); chk("ppu_d", 32'(ppu_ld), 32'(d)); end
        if (exp_s[1]) chk("ppu_ra", 32'(ppu_ra), 32'(a[2:0]));
        if (exp_s[0]) begin chk("cart_a", 32'(cart_la), 32'(a)); chk("cart_d", 32'(cart_ld), 32'(d)); end
    endtask

    // Starts on the negedge right after reset release.
    task automatic cadence(input int periods);
        for (int k = 0; k < periods * CE_DIV; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            chk("ce_cadence", 32'(bus.cpu_ce), 32'((k % CE_DIV) == CE_DIV - 1));
            chk("idle_strobes", 32'({bus.ram_we, bus.ppu_w, bus.ppu_r, bus.cart_w}), 32'd0);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        logic [7:0] q, held_i;
        logic [7:0] jexp [10];
        int base, b_rw, b_pr, n, b_pw;
        logic [15:0] a;
        bit r, w;
        int rw;

        jexp = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41};
        bus.cpu_a = 16'h0; bus.cpu_d = 8'h0; bus.cpu_r = 1'b0; bus.cpu_w = 1'b0;
        bus.joy1 = 8'h00; bus.joy2 = 8'h00;
        for (int i = 0; i < 8; i++) ppu_regs[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) ref_ram[i] = 8'h00;
        ref_reset();

        repeat (3) @(negedge clock);
        #1;
        chk("rst_cpu_i", 32'(bus.cpu_i), 32'h0);
        chk("rst_ce", 32'(bus.cpu_ce), 32'h0);
        chk("rst_strobes", 32'({bus.ram_we, bus.ppu_w, bus.ppu_r, bus.cart_w}), 32'd0);
        @(negedge clock); reset_n = 1'b1;
        cadence(3);

        // RAM mirroring
        do_access(1'b0, 1'b1, 16'h0800, 8'h5A, q);
        chk("ram_mirror_a", 32'(ram_la), 32'h000);
        do_access(1'b1, 1'b0, 16'h0000, 8'h00, q);
        chk("ram_mirror_rd", 32'(q), 32'h5A);

        // PPU register mirroring
        do_access(1'b0, 1'b1, 16'h2006, 8'h21, q);
        do_access(1'b0, 1'b1, 16'h2006, 8'h08, q);
        chk("ppu_w_idx", 32'(ppu_la), 32'd6);
        do_access(1'b1, 1'b0, 16'h3FFF, 8'h00, q);
        chk("ppu_r_idx", 32'(ppu_ra), 32'd7);
        chk("ppu_rd", 32'(q), 32'(ppu_regs[7]));

        // Joypad serial read
        bus.joy1 = 8'h81;
        do_access(1'b0, 1'b1, 16'h4016, 8'h01, q);
        do_access(1'b0, 1'b1, 16'h4016, 8'h00, q);
        for (int i = 0; i < 10; i++) begin
            do_access(1'b1, 1'b0, 16'h4016, 8'h00, q);
            chk("joy_seq", 32'(q), 32'(jexp[i]));
        end

        // OAM DMA from page $02 with a CPU write stalled behind it
        for (int i = 0; i < 256; i++) do_access(1'b0, 1'b1, 16'h0200 + 16'(i), 8'(i), q);
        held_i = bus.cpu_i;
        base = ppu_wq.size(); b_rw = n_ram_we; b_pr = n_ppu_r;
        do_access(1'b0, 1'b1, 16'h4014, 8'h02, q);
        bus.cpu_w = 1'b1; bus.cpu_a = 16'h0300; bus.cpu_d = 8'hEE;
        ref_ram[16'h0300] = 8'hEE;
        n = 0;
        for (int i = 1; i <= 600 * CE_DIV; i++) begin
            @(negedge clock);
            if (bus.cpu_ce) begin n = i; break; end
        end
        chk("dma_ce_gap", n, 514 * CE_DIV);
        @(posedge clock); #1;
        bus.cpu_w = 1'b0;
        chk("dma_ppu_w_count", ppu_wq.size() - base, 256);
        for (int i = 0; i < 256; i++)
            chk("dma_ppu_w", (base + i < ppu_wq.size()) ? 32'(ppu_wq[base + i]) : 32'hFFFF,
                32'({3'd4, 8'(i)}));
        chk("dma_stalled_wr", n_ram_we - b_rw, 1);
        chk("dma_no_ppu_r", n_ppu_r - b_pr, 0);
        chk("dma_cpu_i_hold", 32'(bus.cpu_i), 32'(held_i));
        do_access(1'b1, 1'b0, 16'h0300, 8'h00, q);

        // Reset in the middle of a DMA
        base = ppu_wq.size();
        do_access(1'b0, 1'b1, 16'h4014, 8'h02, q);
        n = 0;
        for (int i = 0; i < 300 * CE_DIV; i++) begin
            @(negedge clock);
            if (ppu_wq.size() - base >= 100) begin n = 1; break; end
        end
        chk("dma_reach_idx100", n, 1);
        reset_n = 1'b0;
        b_pw = n_ppu_w; b_rw = n_ram_we;
        ref_reset();
        repeat (3) begin
            @(negedge clock); #1;
            chk("mid_rst_cpu_i", 32'(bus.cpu_i), 32'h0);
            chk("mid_rst_ce", 32'(bus.cpu_ce), 32'h0);
        end
        @(negedge clock); reset_n = 1'b1;
        cadence(2);
        chk("no_ppu_w_after_rst", n_ppu_w - b_pw, 0);
        chk("no_ram_we_after_rst", n_ram_we - b_rw, 0);

        // Random accesses across the whole map
        for (int it = 0; it < 160; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.joy1 = 8'($urandom); bus.joy2 = 8'($urandom);
            end
            case ($urandom_range(0, 5))
                0, 1:    a = 16'($urandom_range(0, 16'h1FFF));
                2:       a = 16'($urandom_range(16'h2000, 16'h3FFF));
                3:       a = 16'h4000 | 16'($urandom_range(0, 31));
                4:       a = 16'($urandom_range(16'h4020, 16'hFFFF));
                default: a = ($urandom_range(0, 1) == 1) ? 16'h4016 : 16'h4017;
            endcase
            if (a == 16'h4014) a = 16'h4016;
            rw = int'($urandom_range(0, 3));
            r = (rw != 1);
            w = (rw == 1) || (rw == 2);
            do_access(r, w, a, 8'($urandom), q);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_bus.md
Name: cpu_bus

Overview:
- Bus responder for the Dendy CPU. Produces the CPU clock-enable and decodes every CPU access to internal 2 KB RAM, PPU registers, joypad ports and cartridge.
- Returns read data on the CPU input bus.
- Contains the $4014 OAM DMA engine, which stalls the CPU by withholding the enable.

Parameters:
- CE_DIV, 14, system clocks per CPU cycle (25 MHz / 14 ≈ 1.786 MHz). Legal range 6..255.

Ports:
- clock  in  1  25 MHz system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_a  in  16  CPU address (A)
- cpu_d  in  8  CPU write data (D)
- cpu_r  in  1  CPU read request (R)
- cpu_w  in  1  CPU write request (W)
- cpu_i  out  8  read data to CPU (I), registered
- cpu_ce  out  1  CPU chip-enable pulse
- ram_a  out  11  RAM address
- ram_d  out  8  RAM write data
- ram_q  in  8  RAM read data, 1-clock latency
- ram_we  out  1  RAM write strobe
- ppu_a  out  3  PPU register index
- ppu_d  out  8  PPU write data
- ppu_q  in  8  PPU read data, 1-clock latency
- ppu_r  out  1  PPU read strobe
- ppu_w  out  1  PPU write strobe
- cart_a  out  16  cartridge address
- cart_d  out  8  cartridge write data
- cart_q  in  8  cartridge read data, 1-clock latency
- cart_w  out  1  cartridge write strobe
- joy1  in  8  pad 1 buttons {R,L,D,U,St,Se,B,A}, 1 = pressed
- joy2  in  8  pad 2 buttons, same order

Behaviour:
- Reset (async): phase=0, cpu_ce=0, cpu_i=0x00, all strobes=0, DMA idle, joypad strobe=0, both shift registers=0x00.
- Phase counter runs 0..CE_DIV-1 and wraps. One CPU bus cycle equals one counter period.
  - Phase 0: the bus master's address/data are stable. The master is the CPU, or DMA when active.
  - Phase 1: one-clock strobe (ram_we/ppu_r/ppu_w/cart_w) for the decoded target. Reads are also issued to RAM/cart here (address driven; no strobe needed).
  - Phase 3: read mux is captured into cpu_i. cpu_i holds until the next phase-3 capture of a read.
  - Phase CE_DIV-1: cpu_ce=1 for exactly one clock, unless DMA is active.
- Address decode (cpu_r takes priority if both r and w are asserted):
  - $0000-$1FFF: RAM, ram_a=A[10:0] (mirrored ×4).
  - $2000-$3FFF: PPU, ppu_a=A[2:0] (mirrored every 8).
  - $4014 write: start DMA with page P=cpu_d.
  - $4016 write: joypad strobe=D[0].
  - $4016 read: {7'b0100000, sr1[0]}. $4017 read: {7'b0100000, sr2[0]}.
  - Other $4000-$401F: reads return 0x00, writes are ignored.
  - $4020-$FFFF: cartridge, cart_a=A.
- Joypad:
  - While strobe=1, sr1/sr2 reload from joy1/joy2 every clock.
  - When strobe=0, a $4016/$4017 read shifts the corresponding register right at phase 3, after capture, with 1 inserted at the MSB. After 8 reads, further reads return bit0=1.
- OAM DMA:
  - A write to $4014 arms DMA. DMA begins on the next CPU cycle. The $4014 cycle itself completes with cpu_ce.
  - DMA occupies 513 CPU-cycle periods with no cpu_ce: 1 idle period, then 256 read/write pairs for idx=0..255.
  - Read period: decode address {P,idx} exactly as a CPU read (RAM/PPU/cart/IO); data is latched at phase 3.
  - Write period: ppu_a=4, ppu_d=latched byte, ppu_w at phase 1.
  - After the last write, normal cpu_ce resumes at the end of the following period.
  - A $4014 write during DMA cannot occur because the CPU is stalled.
- Reset mid-DMA aborts immediately; no further strobes.
- cpu_i is not updated by DMA reads.
- Write data outputs (ram_d/ppu_d/cart_d) follow cpu_d, or the DMA latch during DMA. They are meaningful only when the matching strobe is 1.

Test Plan:
- Reset, run 3 CPU periods -> cpu_ce pulses every 14 clocks, exactly 1 clock wide, first at clock 13; all strobes 0.
- CPU write 0x5A to $0800, then read $0000 -> ram_we once with ram_a=0x000, ram_d=0x5A; the read returns cpu_i=0x5A (ram model).
- Write $2006 twice, read $3FFF -> ppu_w with ppu_a=6; ppu_r with ppu_a=7; cpu_i=ppu_q value.
- joy1=0x81; write $4016=1 then 0; 10 reads of $4016 -> returned bytes 0x41,0x40,0x40,0x40,0x40,0x40,0x40,0x41,0x41,0x41.
- RAM $0200-$02FF=idx; write $4014=0x02 -> no cpu_ce for 513 periods; 256 ppu_w with ppu_a=4, data 0x00..0xFF in order; cpu_ce resumes after that.
- Assert reset_n=0 during DMA idx=100, release -> no ppu_w after reset; normal cpu_ce cadence restarts from phase 0.
